// File: rtl/planar_pred_4x4_pkg.sv
// Shared constants, state encoding and row types for the 4x4 planar predictor.
package planar_pred_4x4_pkg;

   localparam int DW    = 8;
   localparam int N     = 4;
   localparam int ACC_W = 11;
   localparam int RND   = 4;
   localparam int SHIFT = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECON = 2'd1,
      S_GEN   = 2'd2
   } state_e;

   typedef logic [DW-1:0]        sample_t;
   typedef logic [N-1:0][DW-1:0] row_t;

endpackage

// File: rtl/planar_row_calc.sv
// Combinational HEVC planar interpolation of one 4-sample row from the
// reconstructed references and the row index.
module planar_row_calc
   import planar_pred_4x4_pkg::*;
(
   input  logic [DW-1:0] l_y,
   input  logic [DW-1:0] tr,
   input  logic [DW-1:0] bl,
   input  row_t          t,
   input  logic [1:0]    y,
   output row_t          pred
);

   logic [N-1:0][ACC_W-1:0] acc;

   // The four weights always sum to 8, so 11 bits hold the rounded sum without
   // overflow and the shifted result never needs clipping.
   always_comb begin
      acc  = '0;
      pred = '0;
      for (int x = 0; x < N; x++) begin
         acc[x] = ACC_W'(N - 1 - x) * ACC_W'(l_y)
                + ACC_W'(x + 1) * ACC_W'(tr)
                + (ACC_W'(N - 1) - ACC_W'(y)) * ACC_W'(t[x])
                + (ACC_W'(y) + ACC_W'(1)) * ACC_W'(bl)
                + ACC_W'(RND);
         pred[x] = acc[x][ACC_W-1:SHIFT];
      end
   end

endmodule

// File: rtl/planar_pred_4x4.sv
// 4x4 planar predictor: captures difference-coded references, reconstructs
// them, then streams the block one row per cycle over valid/ready.
module planar_pred_4x4
   import planar_pred_4x4_pkg::*;
(
   input  logic          CLK1,
   input  logic          RST_N,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [DW-1:0] REF_TOP_F0,
   input  logic [DW-1:0] REF_TOP_F1,
   input  logic [DW-1:0] REF_TOP_F2,
   input  logic [DW-1:0] REF_TOP_F3,
   input  logic [DW-1:0] REF_TOP_F4,
   input  logic [DW-1:0] REF_TOP_F5,
   input  logic [DW-1:0] REF_TOP_F6,
   input  logic [DW-1:0] REF_TOP_F7,
   input  logic [DW-1:0] REF_LEFT_F0,
   input  logic [DW-1:0] REF_LEFT_F1,
   input  logic [DW-1:0] REF_LEFT_F2,
   input  logic [DW-1:0] REF_LEFT_F3,
   input  logic [DW-1:0] REF_LEFT_F4,
   input  logic [DW-1:0] REF_LEFT_F5,
   input  logic [DW-1:0] REF_LEFT_F6,
   input  logic [DW-1:0] REF_LEFT_F7,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [1:0]    OUT_ROW,
   output logic          OUT_LAST,
   output logic [DW-1:0] PRED_X0,
   output logic [DW-1:0] PRED_X1,
   output logic [DW-1:0] PRED_X2,
   output logic [DW-1:0] PRED_X3
);

   state_e     state_q, state_d;
   row_t       t_q, t_d, l_q, l_d, pred_q, pred_d;
   sample_t    tr_q, tr_d, bl_q, bl_d;
   logic [1:0] y_q, y_d;
   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;
   logic       out_last_q, out_last_d;
   logic       load;
   row_t       row_pred;
   row_t       top_in, left_in;
   logic       unused_refs;

   assign top_in      = {REF_TOP_F3, REF_TOP_F2, REF_TOP_F1, REF_TOP_F0};
   assign left_in     = {REF_LEFT_F3, REF_LEFT_F2, REF_LEFT_F1, REF_LEFT_F0};
   assign unused_refs = ^{REF_TOP_F5, REF_TOP_F6, REF_TOP_F7,
                          REF_LEFT_F5, REF_LEFT_F6, REF_LEFT_F7};

   // The raw differences are captured into t_q/l_q and overwritten in place by
   // the reconstructed samples during RECON.
   always_comb begin
      state_d    = state_q;
      t_d        = t_q;
      l_d        = l_q;
      tr_d       = tr_q;
      bl_d       = bl_q;
      y_d        = y_q;
      in_ready_d = in_ready_q;
      load       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (IN_VALID && in_ready_q) begin
               t_d        = top_in;
               l_d        = left_in;
               tr_d       = REF_TOP_F4;
               bl_d       = REF_LEFT_F4;
               in_ready_d = 1'b0;
               state_d    = S_RECON;
            end
         end
         S_RECON: begin
            for (int x = 0; x < N; x++) begin
               t_d[x] = tr_q - t_q[x];
               l_d[x] = bl_q - l_q[x];
            end
            y_d     = 2'd0;
            load    = 1'b1;
            state_d = S_GEN;
         end
         S_GEN: begin
            if (out_valid_q && OUT_READY) begin
               if (y_q == 2'd3) begin
                  in_ready_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  y_d  = y_q + 2'd1;
                  load = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the row calculator sees next-state references and row index, so a
   // row is registered on the same edge that advances the counter; the output
   // logic sits in its own always_comb to keep that path free of false loops.
   planar_row_calc u_row_calc (
      .l_y  (l_d[y_d]),
      .tr   (tr_d),
      .bl   (bl_d),
      .t    (t_d),
      .y    (y_d),
      .pred (row_pred)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      pred_d      = pred_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_last_d  = (y_d == 2'd3);
         pred_d      = row_pred;
      end else if (out_valid_q && OUT_READY) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   // NOTE: every register, reference storage included, is cleared by reset so
   // an aborted block leaves no stale samples behind.
   always_ff @(posedge CLK1 or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         t_q         <= '0;
         l_q         <= '0;
         tr_q        <= '0;
         bl_q        <= '0;
         y_q         <= 2'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         pred_q      <= '0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         l_q         <= l_d;
         tr_q        <= tr_d;
         bl_q        <= bl_d;
         y_q         <= y_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         pred_q      <= pred_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_ROW   = y_q;
   assign OUT_LAST  = out_last_q;
   assign PRED_X0   = pred_q[0];
   assign PRED_X1   = pred_q[1];
   assign PRED_X2   = pred_q[2];
   assign PRED_X3   = pred_q[3];

endmodule
